// File: rtl/ssd_pkg.sv
// ssd_pkg: shared state encoding, segment patterns and nibble decoder for the display scanner.
package ssd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;
  localparam logic [7:0] SEG_0     = 8'b0000_0011;
  localparam logic [7:0] SEG_1     = 8'b1001_1111;
  localparam logic [7:0] SEG_2     = 8'b0010_0101;
  localparam logic [7:0] SEG_3     = 8'b0000_1101;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b0100_1001;
  localparam logic [7:0] SEG_6     = 8'b0100_0001;
  localparam logic [7:0] SEG_7     = 8'b0001_1111;
  localparam logic [7:0] SEG_8     = 8'b0000_0001;
  localparam logic [7:0] SEG_9     = 8'b0000_1001;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0: seg_decode = SEG_0;
      4'd1: seg_decode = SEG_1;
      4'd2: seg_decode = SEG_2;
      4'd3: seg_decode = SEG_3;
      4'd4: seg_decode = SEG_4;
      4'd5: seg_decode = SEG_5;
      4'd6: seg_decode = SEG_6;
      4'd7: seg_decode = SEG_7;
      4'd8: seg_decode = SEG_8;
      4'd9: seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 16-cycle shift-add-3 binary to five-digit BCD converter.
module bin2bcd_seq (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [15:0] bin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [19:0] bcd_o
);
  import ssd_pkg::*;
  state_e      state_q, state_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d, adj;
  logic [3:0]  cnt_q, cnt_d;
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < 5; k++)
      adj[k*4 +: 4] = bcd_q[k*4 +: 4] >= 4'd5 ? bcd_q[k*4 +: 4] + 4'd3 : bcd_q[k*4 +: 4];
  end
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = SHIFT;
        bin_d   = bin_i;
        bcd_d   = '0;
        cnt_d   = '0;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q + 4'd1;
        state_d        = cnt_q == 4'd15 ? COMMIT : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == COMMIT;
  assign bcd_o  = bcd_q;
endmodule

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller: converts a binary value to BCD and time-multiplexes it across eight
// active-low seven-segment digits with optional leading-zero blanking.
module ssd_scan_controller #(
  parameter int TICK_CYCLES = 100000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] value_i,
  input  logic        load_i,
  input  logic        blank_zeros_i,
  input  logic        enable_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  an_o,
  output logic [7:0]  seg_o
);
  import ssd_pkg::*;
  localparam int TW = $clog2(TICK_CYCLES);
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    idx_q, idx_d;
  logic [19:0]   disp_q, disp_d, bcd_w;
  logic [31:0]   dig_w;
  logic [7:0]    an_q, an_d, seg_q, seg_d;
  logic          blank_w, wrap_w;
  bin2bcd_seq u_conv (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (load_i),
    .bin_i   (value_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .bcd_o   (bcd_w)
  );
  // Shifting the zero-padded buffer right by idx digits leaves digits idx..4; all zero means leading zero.
  always_comb begin
    wrap_w  = tick_q == TW'(TICK_CYCLES - 1);
    tick_d  = wrap_w ? '0 : tick_q + 1'b1;
    idx_d   = wrap_w ? idx_q + 3'd1 : idx_q;
    disp_d  = done_o ? bcd_w : disp_q;
    dig_w   = {12'h000, disp_q};
    blank_w = !enable_i || idx_q >= 3'd5 ||
              (blank_zeros_i && idx_q != 3'd0 && (dig_w >> {idx_q, 2'b00}) == 32'd0);
    an_d    = blank_w ? 8'hFF : ~(8'd1 << idx_q);
    seg_d   = blank_w ? SEG_BLANK : seg_decode(dig_w[{idx_q, 2'b00} +: 4]);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tick_q <= '0;
      idx_q  <= '0;
      disp_q <= '0;
      an_q   <= 8'hFF;
      seg_q  <= SEG_BLANK;
    end else begin
      tick_q <= tick_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end
  assign an_o  = an_q;
  assign seg_o = seg_q;
endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb_ssd_scan_controller: table vectors, directed corner sequences and random stimulus
// checked every cycle against a value-level model of the display controller.
module tb_ssd_scan_controller;
  localparam int TICK = 4;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1, load_i = 1'b0, blank_zeros_i = 1'b0, enable_i = 1'b1;
  logic [15:0] value_i = '0;
  logic        busy_o, done_o;
  logic [7:0]  an_o, seg_o;
  ssd_scan_controller #(.TICK_CYCLES(TICK)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .value_i(value_i), .load_i(load_i),
    .blank_zeros_i(blank_zeros_i), .enable_i(enable_i),
    .busy_o(busy_o), .done_o(done_o), .an_o(an_o), .seg_o(seg_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct packed {
    logic [15:0] value;
    logic        bz;
    logic [31:0] digs;
  } vec_t;
  logic [7:0] segtab [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
                              8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00001001};
  int p10 [5] = '{1, 10, 100, 1000, 10000};
  int n_checks = 0, n_fail = 0, cyc = 0;
  int m_conv, m_val, m_buf, m_tick, m_idx;
  logic [7:0] m_an, m_seg;
  vec_t vecs [10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic model(input logic r, ld, input logic [15:0] v, input logic e, b);
    logic blank;
    logic [7:0] one;
    one = 8'd1;
    if (r) begin
      m_conv = 0; m_val = 0; m_buf = 0; m_tick = 0; m_idx = 0;
      m_an = 8'hFF; m_seg = 8'hFF;
    end else begin
      blank = !e || m_idx >= 5 || (b && m_idx >= 1 && m_buf < p10[m_idx]);
      m_an  = blank ? 8'hFF : ~(one << m_idx);
      m_seg = blank ? 8'hFF : segtab[(m_buf / p10[m_idx]) % 10];
      if (m_conv == 17) m_buf = m_val;
      if (m_conv == 0) begin
        if (ld) begin m_conv = 1; m_val = int'(v); end
      end else m_conv = m_conv == 17 ? 0 : m_conv + 1;
      m_tick++;
      if (m_tick == TICK) begin m_tick = 0; m_idx = (m_idx + 1) % 8; end
    end
  endtask
  task automatic step(input logic r, ld, input logic [15:0] v, input logic e, b);
    reset_i = r; load_i = ld; value_i = v; enable_i = e; blank_zeros_i = b;
    @(posedge clk_i);
    model(r, ld, v, e, b);
    @(negedge clk_i);
    cyc++;
    chk("busy", 32'(busy_o), 32'(m_conv != 0));
    chk("done", 32'(done_o), 32'(m_conv == 17));
    chk("an", 32'(an_o), 32'(m_an));
    chk("seg", 32'(seg_o), 32'(m_seg));
  endtask
  task automatic scan_check(input logic bz, input logic [31:0] digs);
    logic [7:0] seen [8];
    logic [3:0] n;
    for (int k = 0; k < 8; k++) seen[k] = 8'hFF;
    repeat (8 * TICK + 4) begin
      step(1'b0, 1'b0, 16'd0, 1'b1, bz);
      for (int k = 0; k < 8; k++) if (!an_o[k]) seen[k] = seg_o;
    end
    for (int k = 0; k < 8; k++) begin
      n = digs[k*4 +: 4];
      chk($sformatf("vec digit%0d", k), 32'(seen[k]), 32'(n == 4'hF ? 8'hFF : segtab[n]));
    end
  endtask
  task automatic run_vec(input vec_t vv);
    step(1'b0, 1'b1, vv.value, 1'b1, vv.bz);
    repeat (19) step(1'b0, 1'b0, 16'd0, 1'b1, vv.bz);
    scan_check(vv.bz, vv.digs);
  endtask
  initial begin
    int ndone, d0, d1;
    vecs[0] = '{16'd12345, 1'b0, 32'hFFF12345};
    vecs[1] = '{16'd12345, 1'b1, 32'hFFF12345};
    vecs[2] = '{16'd42,    1'b1, 32'hFFFFFF42};
    vecs[3] = '{16'd42,    1'b0, 32'hFFF00042};
    vecs[4] = '{16'd0,     1'b1, 32'hFFFFFFF0};
    vecs[5] = '{16'd0,     1'b0, 32'hFFF00000};
    vecs[6] = '{16'd65535, 1'b0, 32'hFFF65535};
    vecs[7] = '{16'd1000,  1'b1, 32'hFFFF1000};
    vecs[8] = '{16'd9,     1'b0, 32'hFFF00009};
    vecs[9] = '{16'd10000, 1'b1, 32'hFFF10000};
    step(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'd77, 1'b1, 1'b0);
    chk("reset an", 32'(an_o), 32'hFF);
    chk("reset seg", 32'(seg_o), 32'hFF);
    chk("reset busy", 32'(busy_o), 32'd0);
    scan_check(1'b0, 32'hFFF00000);
    scan_check(1'b1, 32'hFFFFFFF0);
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    // back-to-back loads with an ignored request in between
    ndone = 0; d0 = -1; d1 = -1;
    for (int j = 0; j <= 40; j++) begin
      step(1'b0, j == 0 || j == 5 || j == 18, j == 18 ? 16'd0 : (j == 5 ? 16'd123 : 16'd65535), 1'b1, 1'b0);
      if (done_o) begin
        if (ndone == 0) d0 = j + 1; else d1 = j + 1;
        ndone++;
      end
    end
    chk("b2b done count", 32'(ndone), 32'd2);
    chk("b2b first done", 32'(d0), 32'd17);
    chk("b2b second done", 32'(d1), 32'd35);
    scan_check(1'b1, 32'hFFFFFFF0);
    // display disabled while scanning continues
    repeat (40) begin
      step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
      chk("disabled an", 32'(an_o), 32'hFF);
    end
    repeat (40) step(1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
    run_vec(vecs[0]);
    // reset aborts a conversion in flight
    ndone = 0;
    for (int j = 0; j <= 30; j++) begin
      step(j == 8, j == 0, 16'd999, 1'b1, 1'b0);
      if (done_o) ndone++;
    end
    chk("abort no done", 32'(ndone), 32'd0);
    scan_check(1'b0, 32'hFFF00000);
    run_vec('{16'd999, 1'b0, 32'hFFF00999});
    for (int j = 0; j < 1500; j++) begin
      logic [15:0] v;
      v = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 120)) : 16'($urandom);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0, v,
           $urandom_range(0, 9) != 0, 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ssd_scan_controller.md
# ssd_scan_controller

Sequential driver for the board's eight-digit, common-cathode-bus seven-segment display. It takes a 16-bit binary value, such as the snake length or a score, and converts it to five BCD digits with a multi-cycle shift-add-3 engine. It double-buffers the result and time-multiplexes the shared cathode bus across all eight anodes. It replaces the ad-hoc two-digit anode toggle in the game top level and serves as the single owner of An7..An0 and the cathodes.

## Interface
- TICK_CYCLES, default 100000: Clk cycles each digit stays active (1 kHz per digit at 100 MHz); minimum 2.
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Value  in  16  unsigned binary value to display; sampled only on an accepted Load.
- Load  in  1  conversion request; accepted only in IDLE.
- BlankZeros  in  1  suppresses leading zeros on digits 4..1; digit 0 is always shown.
- Enable  in  1  display enable; 0 blanks every digit, while scanning and conversion continue.
- Busy  out  1  high while a conversion is in progress.
- Done  out  1  one-cycle pulse when the new digits are committed to the display buffer.
- An  out  8  active-low anodes; An[0] is the rightmost digit.
- Seg  out  8  active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}; Dp is always 1 (off).

## Operation
- Conversion FSM states:
  - IDLE: Load=1 latches Value into the shift register, clears the BCD accumulator and the bit counter, and moves to SHIFT.
  - SHIFT: runs exactly 16 cycles. Each cycle, every BCD nibble ≥5 gets +3, then {bcd,bin} shifts left by 1. After the 16th shift the FSM moves to COMMIT.
  - COMMIT: copies the 20-bit BCD result into the display buffer (digits 4..0), pulses Done, and returns to IDLE.
- Load asserted in SHIFT or COMMIT is ignored, not queued. The display buffer is unchanged until COMMIT, so no partial value is ever shown.
- Scan counter:
  - tick runs 0..TICK_CYCLES-1. On wrap, idx advances by 1 modulo 8 (7→0).
  - Scanning is independent of the FSM.
- Blank rule for digit idx: Enable=0, or idx≥5, or (BlankZeros=1 and 1≤idx≤4 and every buffered digit from idx up to 4 is 0).
- Output rule:
  - Blank digit: An=8'hFF, Seg=8'hFF.
  - Otherwise: An=~(8'b1<<idx), Seg=decode(digit[idx]).
- Decode table, {Ca..Dp}:
  - 0→00000011, 1→10011111, 2→00100101, 3→00001101, 4→10011001
  - 5→01001001, 6→01000001, 7→00011111, 8→00000001, 9→00001001
  - any other nibble→11111111

## Timing
- Reset values: state=IDLE, tick=0, idx=0, display buffer all zero, Busy=0, Done=0, An=8'hFF, Seg=8'hFF.
- Load accepted at cycle t:
  - Busy=1 from t+1 to t+17 inclusive.
  - SHIFT occupies t+1..t+16.
  - COMMIT at t+17, with Done=1 during t+17 only.
  - The new buffer is visible on An/Seg from t+19 (buffer at t+18, output register at t+19).
  - IDLE at t+18, where a new Load is accepted.
  - Back-to-back conversion period: 18 cycles.
- An and Seg are registered. They reflect idx, buffer, Enable and BlankZeros as sampled one cycle earlier, and An and Seg always change on the same edge.
- Reset asserted mid-conversion aborts it: no Done, buffer cleared, FSM back in IDLE on the next cycle.
- Reset has priority over Load in the same cycle.

## Structure
- Package ssd_pkg:
  - FSM state encoding (IDLE/SHIFT/COMMIT).
  - The SEG_0..SEG_9 and SEG_BLANK constants.
  - A seg_decode function for a 4-bit nibble.
- Sub-module bin2bcd_seq: Clk, Reset, Start, Bin[15:0], Busy, Done, Bcd[19:0]. It contains the FSM, the shift register and the bit counter.
- The top of this block owns the display buffer, the tick/idx counters, the blanking logic and the output registers.

## Test plan
- Reset for 2 cycles, then release: An=8'hFF and Seg=8'hFF until the first output update. Then, with TICK_CYCLES=4 and buffer 0, digit 0 shows SEG_0 and An cycles 11111110 → 11111111 (idx 1..7 blanked only if BlankZeros=1; otherwise digits 1..4 show 0).
- Load with Value=12345 at cycle t: Busy high t+1..t+17, Done pulses at t+17, and the scan then shows 5,4,3,2,1 on digits 0..4 with digits 5..7 blank.
- BlankZeros=1 with Value=42: only An[0] (SEG_2) and An[1] (SEG_4) are ever low; Value=0 shows only SEG_0 on digit 0.
- Value=65535 then Value=0 loaded back to back: Load pulses at t and t+18 are both accepted, and Done pulses at t+17 and t+35. A Load pulse at t+5 is ignored (one Done only in that window).
- Enable=0 for 40 cycles during scanning: An=8'hFF and Seg=8'hFF throughout, idx keeps advancing, and the display resumes at the correct idx when Enable returns to 1.
- Reset asserted at t+8 of a conversion of 999: no Done, buffer reads 0 on the scan, and a subsequent Load works normally.
